mmio_bus_bridge: RTL and testbench

//  Parametrised successor of the single-cycle CPU's data-memory/peripheral interface. Sits between
//  the core's load/store port and N_CH memory-mapped slaves (DRAM, 7-seg, LEDs, switches, buttons).

---
 rtl/mmio_pkg.sv | 33 +++
 rtl/mmio_bus_bridge_if.sv | 38 +++
 rtl/mmio_addr_decoder.sv | 34 +++
 rtl/mmio_bus_bridge.sv | 156 +++++++++++++++
 tb/tb_mmio_bus_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO bus bridge.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Default four-slave map: DRAM, 7-seg digits, LEDs, switches
  localparam logic [31:0] DRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DRAM_MASK = 32'hFFE0_0000;
  localparam logic [31:0] DIG_BASE  = 32'hFFFF_F000;
  localparam logic [31:0] DIG_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] LED_BASE  = 32'hFFFF_F060;
  localparam logic [31:0] LED_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] SW_BASE   = 32'hFFFF_F070;
  localparam logic [31:0] SW_MASK   = 32'hFFFF_FFF0;

  // Channel 0 sits in the least significant slice
  localparam logic [127:0] DEF_CH_BASE = {SW_BASE, LED_BASE, DIG_BASE, DRAM_BASE};
  localparam logic [127:0] DEF_CH_MASK = {SW_MASK, LED_MASK, DIG_MASK, DRAM_MASK};

  // Read data returned on any error completion
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// CPU load/store port plus per-channel slave handshake, bundled for the bridge.
// Latency: wires only.
// Backpressure: cpu side waits on cpu_ready; slaves complete with ch_ack.
interface mmio_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_CH   = 4
) ();

  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DATA_W-1:0]      cpu_wdata;
  logic [DATA_W/8-1:0]    cpu_wstrb;
  logic                   cpu_ready;
  logic [DATA_W-1:0]      cpu_rdata;
  logic                   cpu_err;
  logic [N_CH-1:0]        ch_sel;
  logic                   ch_we;
  logic [ADDR_W-1:0]      ch_addr;
  logic [DATA_W-1:0]      ch_wdata;
  logic [DATA_W/8-1:0]    ch_wstrb;
  logic [N_CH-1:0]        ch_ack;
  logic [N_CH*DATA_W-1:0] ch_rdata;

  // Environment side: CPU requests and slave responses
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb, ch_ack, ch_rdata,
    input  cpu_ready, cpu_rdata, cpu_err, ch_sel, ch_we, ch_addr, ch_wdata, ch_wstrb
  );

  // Bridge side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb, ch_ack, ch_rdata,
    output cpu_ready, cpu_rdata, cpu_err, ch_sel, ch_we, ch_addr, ch_wdata, ch_wstrb
  );

endinterface

// File: rtl/mmio_addr_decoder.sv
// Address-map decoder: one-hot hit, hit index, miss flag and in-window offset.
// Latency: combinational.
// Backpressure: none.
module mmio_addr_decoder #(
  parameter int                     ADDR_W  = 32,
  parameter int                     N_CH    = 4,
  parameter int                     IDX_W   = 2,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [N_CH*ADDR_W-1:0] CH_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_CH-1:0]   hit_oh_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic              miss_o,
  output logic [ADDR_W-1:0] offset_o
);

  // Scan high to low so the lowest matching window overrides the rest
  always_comb begin
    hit_oh_o  = '0;
    hit_idx_o = '0;
    offset_o  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if ((addr_i & CH_MASK[i*ADDR_W +: ADDR_W]) == CH_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_oh_o    = '0;
        hit_oh_o[i] = 1'b1;
        hit_idx_o   = IDX_W'(i);
        offset_o    = addr_i & ~CH_MASK[i*ADDR_W +: ADDR_W];
      end
    end
    miss_o = ~|hit_oh_o;
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU load/store to N_CH MMIO slaves; optional access timeout via BUS_TIMEOUT_EN.
// Latency: 2 cycles req-to-ready when unmapped, 2 + ack wait cycles when mapped.
// Backpressure: one access in flight; cpu_ready pulses once, slaves stall via ch_ack.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter int                     ADDR_W  = 32,
  parameter int                     DATA_W  = 32,
  parameter int                     N_CH    = 4,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE = DEF_CH_BASE,
  parameter logic [N_CH*ADDR_W-1:0] CH_MASK = DEF_CH_MASK
`ifdef BUS_TIMEOUT_EN
  , parameter int                   TIMEOUT_CYC = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  mmio_bus_bridge_if.slave   bus,
  output logic [15:0]        err_cnt
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [N_CH-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [N_CH-1:0]     dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_miss;
  logic [ADDR_W-1:0]   dec_offset;
  logic                expired;

  mmio_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .N_CH    (N_CH),
    .IDX_W   (IDX_W),
    .CH_BASE (CH_BASE),
    .CH_MASK (CH_MASK)
  ) u_dec (
    .addr_i    (bus.cpu_addr),
    .hit_oh_o  (dec_hit),
    .hit_idx_o (dec_idx),
    .miss_o    (dec_miss),
    .offset_o  (dec_offset)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] tcnt_q;

  // Count ACCESS cycles; restarts whenever the bridge leaves ACCESS
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_ACCESS) tcnt_q <= '0;
    else                             tcnt_q <= tcnt_q + 1'b1;
  end

  assign expired = (state_q == ST_ACCESS) && (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state: latch on request, wait for the selected ack (or expiry), respond once
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = dec_offset;
          wdata_d = bus.cpu_wdata;
          wstrb_d = bus.cpu_wstrb;
          sel_d   = dec_hit;
          idx_d   = dec_idx;
          err_d   = dec_miss;
          if (dec_miss) begin
            if (!bus.cpu_we) rdata_d = DATA_W'(ERR_RDATA);
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (|(bus.ch_ack & sel_q)) begin
          if (!we_q) rdata_d = bus.ch_rdata[int'(idx_q)*DATA_W +: DATA_W];
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(ERR_RDATA);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (err_q) err_cnt_d = sat_inc16(err_cnt_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_ready = (state_q == ST_RESP);
  assign bus.cpu_err   = (state_q == ST_RESP) && err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.ch_sel    = (state_q == ST_ACCESS) ? sel_q : '0;
  assign bus.ch_we     = (state_q == ST_ACCESS) && we_q;
  assign bus.ch_addr   = addr_q;
  assign bus.ch_wdata  = wdata_q;
  assign bus.ch_wstrb  = wstrb_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed bench for mmio_bus_bridge with a behavioural slave on every channel.
// Latency: counts cycles from request cycle (1) to the cpu_ready cycle.
// Backpressure: slave ack delay and stray acks set per scenario.
module tb_mmio_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural slave controls and observations
  int          slv_ch    = 0;
  int          slv_delay = 1;
  bit          slv_en    = 1'b0;
  logic [31:0] slv_data  = '0;
  bit          stray_en  = 1'b0;
  int          stray_ch  = 0;
  int          stray_at  = 0;
  int          acc_cyc   = 0;
  int          sel_bad   = 0;
  int          we_seen   = 0;
  int          ready_pulses = 0;
  logic [3:0]  sel_or    = '0;
  logic [31:0] cap_addr  = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  mmio_bus_bridge_if #(.ADDR_W(32), .DATA_W(32), .N_CH(4)) bus ();

  mmio_bus_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    sel_bad = 0; we_seen = 0; ready_pulses = 0; sel_or = '0; stray_en = 1'b0;
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_wstrb = wstrb;
  endtask

  // cyc = index of the cpu_ready cycle, request cycle being 1; 0 if it never came
  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int n = 2; n <= 100; n++) begin
      tick();
      if (bus.cpu_ready === 1'b1) begin
        cyc = n;
        break;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  // Slave model: acks its channel in the slv_delay-th ACCESS cycle, optional stray ack
  initial begin
    logic [3:0] exp_sel;
    bus.ch_ack   = '0;
    bus.ch_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.ch_ack = '0;
      exp_sel = 4'b0001 << slv_ch;
      if (bus.ch_sel !== 4'b0000) begin
        acc_cyc++;
        sel_or = sel_or | bus.ch_sel;
        if (bus.ch_sel !== exp_sel) sel_bad++;
        if (bus.ch_we === 1'b1) we_seen++;
        cap_addr  = bus.ch_addr;
        cap_wdata = bus.ch_wdata;
        cap_wstrb = bus.ch_wstrb;
        if (slv_en && acc_cyc == slv_delay) begin
          bus.ch_ack[slv_ch] = 1'b1;
          bus.ch_rdata[slv_ch*32 +: 32] = slv_data;
        end
        if (stray_en && acc_cyc == stray_at) begin
          bus.ch_ack[stray_ch] = 1'b1;
          bus.ch_rdata[stray_ch*32 +: 32] = 32'hBAD0_BAD0;
        end
      end else begin
        acc_cyc = 0;
      end
      if (bus.cpu_ready === 1'b1) ready_pulses++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
    repeat (3) tick();
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.cpu_ready); end
    checks++; if (bus.cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.cpu_err); end
    checks++; if (bus.ch_sel !== 4'b0000 || bus.ch_we !== 1'b0) begin errors++; $display("FAIL reset_sel got %b/%b want 0000/0", bus.ch_sel, bus.ch_we); end
    checks++; if (bus.cpu_rdata !== 32'h0 || bus.ch_addr !== 32'h0 || bus.ch_wdata !== 32'h0 || bus.ch_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want zeros", bus.cpu_rdata, bus.ch_addr, bus.ch_wdata, bus.ch_wstrb); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_errcnt got %h want 0", err_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait();
    int cyc;
    clear_obs();
    slv_en = 1'b1; slv_ch = 0; slv_delay = 1; slv_data = 32'hCAFE_F00D;
    start_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL rd0_latency got %0d want 3", cyc); end
    checks++; if (bus.cpu_rdata !== 32'hCAFE_F00D || bus.cpu_err !== 1'b0) begin
      errors++; $display("FAIL rd0_data got %h err %b want cafef00d err 0", bus.cpu_rdata, bus.cpu_err); end
    checks++; if (cap_addr !== 32'h40 || sel_or !== 4'b0001 || sel_bad != 0 || we_seen != 0) begin
      errors++; $display("FAIL rd0_chan got addr %h sel %b bad %0d we %0d want 40 0001 0 0", cap_addr, sel_or, sel_bad, we_seen); end
    tick();
    checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rd0_hold got ready %b rdata %h want 0 cafef00d", bus.cpu_ready, bus.cpu_rdata); end
  endtask

  task automatic test_write_led();
    int cyc;
    clear_obs();
    slv_en = 1'b1; slv_ch = 2; slv_delay = 1; slv_data = 32'h0;
    start_req(1'b1, 32'hFFFF_F060, 32'h1234_5678, 4'b0011);
    wait_ready(cyc);
    repeat (2) tick();
    checks++; if (cyc !== 3 || ready_pulses != 1) begin errors++; $display("FAIL wr_led_ready got cyc %0d pulses %0d want 3 1", cyc, ready_pulses); end
    checks++; if (sel_or !== 4'b0100 || sel_bad != 0 || we_seen != 1) begin
      errors++; $display("FAIL wr_led_sel got %b bad %0d we %0d want 0100 0 1", sel_or, sel_bad, we_seen); end
    checks++; if (cap_wdata !== 32'h1234_5678 || cap_wstrb !== 4'b0011 || cap_addr !== 32'h0) begin
      errors++; $display("FAIL wr_led_data got %h %b %h want 12345678 0011 0", cap_wdata, cap_wstrb, cap_addr); end
  endtask

  task automatic test_unmapped();
    int cyc;
    clear_obs();
    slv_en = 1'b0;
    start_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 2 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL unmapped_rd got cyc %0d err %b rdata %h want 2 1 0", cyc, bus.cpu_err, bus.cpu_rdata); end
    tick();
    checks++; if (err_cnt !== 16'd1 || sel_or !== 4'b0000) begin errors++; $display("FAIL unmapped_cnt got %0d sel %b want 1 0000", err_cnt, sel_or); end
    // Write just past the DRAM window: must strobe nothing
    start_req(1'b1, 32'h0020_0000, 32'hFFFF_FFFF, 4'hF);
    wait_ready(cyc);
    tick();
    checks++; if (cyc !== 2 || we_seen != 0 || sel_or !== 4'b0000 || err_cnt !== 16'd2) begin
      errors++; $display("FAIL unmapped_wr got cyc %0d we %0d sel %b cnt %0d want 2 0 0000 2", cyc, we_seen, sel_or, err_cnt); end
  endtask

  task automatic test_delayed_stray();
    int cyc;
    clear_obs();
    slv_en = 1'b1; slv_ch = 1; slv_delay = 5; slv_data = 32'h0000_7E57;
    stray_en = 1'b1; stray_ch = 3; stray_at = 2;
    start_req(1'b0, 32'hFFFF_F004, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 7 || ready_pulses != 0) begin errors++; $display("FAIL delay_latency got %0d early %0d want 7 0", cyc, ready_pulses); end
    checks++; if (bus.cpu_rdata !== 32'h0000_7E57 || bus.cpu_err !== 1'b0) begin
      errors++; $display("FAIL delay_data got %h err %b want 00007e57 0", bus.cpu_rdata, bus.cpu_err); end
    checks++; if (sel_or !== 4'b0010 || sel_bad != 0 || cap_addr !== 32'h4) begin
      errors++; $display("FAIL delay_sel got %b bad %0d addr %h want 0010 0 4", sel_or, sel_bad, cap_addr); end
    stray_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_obs();
    slv_en = 1'b1; slv_ch = 3; slv_delay = 1; slv_data = 32'h0000_00A5;
    start_req(1'b0, 32'hFFFF_F07C, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 3 || bus.cpu_rdata !== 32'hA5 || cap_addr !== 32'hC) begin
      errors++; $display("FAIL b2b_first got cyc %0d rdata %h addr %h want 3 a5 c", cyc, bus.cpu_rdata, cap_addr); end
    // Raised during the ready cycle: taken in the following IDLE cycle
    slv_ch = 0; slv_data = 32'h0BAD_CAFE;
    start_req(1'b0, 32'h001F_FFFC, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 4 || bus.cpu_rdata !== 32'h0BAD_CAFE || cap_addr !== 32'h001F_FFFC || bus.cpu_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second got cyc %0d rdata %h addr %h err %b want 4 0badcafe 1ffffc 0", cyc, bus.cpu_rdata, cap_addr, bus.cpu_err); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    clear_obs();
    slv_en = 1'b0; slv_ch = 3;
    start_req(1'b0, 32'hFFFF_F070, 32'h0, 4'h0);
    repeat (2) tick();
    checks++; if (bus.ch_sel !== 4'b1000) begin errors++; $display("FAIL rstmid_pre got %b want 1000", bus.ch_sel); end
    rst = 1'b1; bus.cpu_req = 1'b0;
    tick();
    checks++; if (bus.ch_sel !== 4'b0000 || bus.cpu_ready !== 1'b0 || err_cnt !== 16'h0) begin
      errors++; $display("FAIL rstmid_abort got sel %b ready %b cnt %0d want 0000 0 0", bus.ch_sel, bus.cpu_ready, err_cnt); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (ready_pulses != 0) begin errors++; $display("FAIL rstmid_noready got %0d want 0", ready_pulses); end
    slv_en = 1'b1; slv_ch = 0; slv_delay = 1; slv_data = 32'h5151_1515;
    start_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 3 || bus.cpu_rdata !== 32'h5151_1515 || cap_addr !== 32'h100) begin
      errors++; $display("FAIL rstmid_new got cyc %0d rdata %h addr %h want 3 51511515 100", cyc, bus.cpu_rdata, cap_addr); end
    tick();
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    clear_obs();
    slv_en = 1'b0; slv_ch = 0;
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 18 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_abort got cyc %0d err %b rdata %h want 18 1 0", cyc, bus.cpu_err, bus.cpu_rdata); end
    tick();
    slv_en = 1'b1; slv_delay = 16; slv_data = 32'h1616_1616;
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_ready(cyc);
    checks++; if (cyc !== 18 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h1616_1616) begin
      errors++; $display("FAIL timeout_ackwins got cyc %0d err %b rdata %h want 18 0 16161616", cyc, bus.cpu_err, bus.cpu_rdata); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_led();
    test_unmapped();
    test_delayed_stray();
    test_back_to_back();
    test_reset_mid_access();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
